// File: rtl/key_scanner_pkg.sv
// Shared definitions for the piano key front end: note codes, key count,
// FSM state encoding and small combinational helpers.
package key_scanner_pkg;

    localparam int NUM_KEYS = 7;
    localparam int NOTE_W   = 4;
    localparam int HOLD_W   = 8;

    // Note codes shared with the Controller and the Buzzer.
    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_DO   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_RE   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_MI   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_FA   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_SOL  = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_LA   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_SI   = 4'd7;

    localparam logic [HOLD_W-1:0] HOLD_MAX  = 8'hFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set (caller checks for zero).
    function automatic logic [2:0] lowest_set(input logic [NUM_KEYS-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Number of set bits.
    function automatic logic [3:0] popcount(input logic [NUM_KEYS-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/key_scanner_if.sv
// Key scanner signal bundle: raw keys in, debounced levels, active note,
// press/release strobes, hold duration and multi-press flag out.
interface key_scanner_if;
    import key_scanner_pkg::*;

    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] keys_stable;
    logic [NOTE_W-1:0]   note_out;
    logic                press_pulse;
    logic                release_pulse;
    logic [HOLD_W-1:0]   hold_ticks;
    logic                multi_press;

    // Drives the key switches, observes the scanner results.
    modport master (
        output keys,
        input  keys_stable,
        input  note_out,
        input  press_pulse,
        input  release_pulse,
        input  hold_ticks,
        input  multi_press
    );

    // The scanner itself.
    modport slave (
        input  keys,
        output keys_stable,
        output note_out,
        output press_pulse,
        output release_pulse,
        output hold_ticks,
        output multi_press
    );
endinterface

// File: rtl/key_scanner_debounce.sv
// One key: two-flop synchroniser followed by a counting debouncer.
// The stable level only flips after the synced input has disagreed with it
// for DB_CYCLES consecutive cycles; any agreement restarts the count.
module key_debounce
    import key_scanner_pkg::*;
#(
    parameter int DB_CYCLES = 2_000_000,
    parameter int DB_W      = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable
);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic [DB_W-1:0] r_cnt;

    // Synchronise the raw switch and debounce the synced level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/key_scanner.sv
// Piano key front end: debounces all keys, tracks a single active note
// (first-held wins, lowest index on ties), emits press/release strobes and
// measures each press in UNIT_CYCLES ticks.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | no active note; waits for any stable key, picks the lowest
//  HELD    | note latched; counts hold ticks until that key is released
module key_scanner
    import key_scanner_pkg::*;
#(
    parameter int DB_CYCLES   = 2_000_000,
    parameter int DB_W        = 21,
    parameter int UNIT_CYCLES = 1_000_000,
    parameter int UNIT_W      = 20
) (
    input  logic          clk,
    input  logic          reset,
    key_scanner_if.slave  bus
);

    logic [NUM_KEYS-1:0] w_stable;
    logic [7:0]          w_stable_ext;
    logic [2:0]          w_low_idx;

    state_t              r_state,      w_state_nxt;
    logic [2:0]          r_cur_idx,    w_cur_idx_nxt;
    logic [NOTE_W-1:0]   r_note,       w_note_nxt;
    logic                r_press,      w_press_nxt;
    logic                r_release,    w_release_nxt;
    logic [HOLD_W-1:0]   r_hold_ticks, w_hold_ticks_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt,   w_hold_cnt_nxt;
    logic [UNIT_W-1:0]   r_presc,      w_presc_nxt;
    logic                r_multi;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .DB_W      (DB_W)
        ) u_db (
            .clk      (clk),
            .reset    (reset),
            .i_raw    (bus.keys[g]),
            .o_stable (w_stable[g])
        );
    end

    // Padded to 8 bits so the 3-bit current index can address it directly.
    assign w_stable_ext = {1'b0, w_stable};
    assign w_low_idx    = lowest_set(w_stable);

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_cur_idx_nxt    = r_cur_idx;
        w_note_nxt       = r_note;
        w_press_nxt      = 1'b0;
        w_release_nxt    = 1'b0;
        w_hold_ticks_nxt = r_hold_ticks;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_presc_nxt      = r_presc;

        case (r_state)
            ST_IDLE: begin
                w_note_nxt = NOTE_REST;
                if (w_stable != '0) begin
                    w_cur_idx_nxt  = w_low_idx;
                    w_note_nxt     = NOTE_W'(w_low_idx) + NOTE_DO;
                    w_press_nxt    = 1'b1;
                    w_hold_cnt_nxt = '0;
                    w_presc_nxt    = '0;
                    w_state_nxt    = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!w_stable_ext[r_cur_idx]) begin
                    w_hold_ticks_nxt = r_hold_cnt;
                    w_release_nxt    = 1'b1;
                    w_note_nxt       = NOTE_REST;
                    w_state_nxt      = ST_IDLE;
                end else if (r_presc == UNIT_W'(UNIT_CYCLES - 1)) begin
                    w_presc_nxt = '0;
                    if (r_hold_cnt != HOLD_MAX) begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end else begin
                    w_presc_nxt = r_presc + UNIT_W'(1);
                end
            end
            default: begin
                w_note_nxt  = NOTE_REST;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cur_idx    <= 3'd0;
            r_note       <= NOTE_REST;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_hold_ticks <= '0;
            r_hold_cnt   <= '0;
            r_presc      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_idx    <= w_cur_idx_nxt;
            r_note       <= w_note_nxt;
            r_press      <= w_press_nxt;
            r_release    <= w_release_nxt;
            r_hold_ticks <= w_hold_ticks_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_presc      <= w_presc_nxt;
        end
    end

    // Flag chords; trails keys_stable by one cycle since it is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_multi <= 1'b0;
        end else begin
            r_multi <= (popcount(w_stable) > 4'd1);
        end
    end

    assign bus.keys_stable   = w_stable;
    assign bus.note_out      = r_note;
    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.hold_ticks    = r_hold_ticks;
    assign bus.multi_press   = r_multi;

endmodule

// File: tb/tb_key_scanner.sv
// Bench for key_scanner with DB_CYCLES=4, UNIT_CYCLES=10.
// Stimulus pushes expected press/release events; a monitor pops them when
// the DUT strobes. Level checks at known cycles are made inline.
module tb_key_scanner;
    import key_scanner_pkg::*;

    typedef struct {
        bit         is_press;
        logic [3:0] note;
        logic [7:0] hold;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    ev_t  q[$];

    key_scanner_if u_if ();

    key_scanner #(
        .DB_CYCLES   (4),
        .DB_W        (3),
        .UNIT_CYCLES (10),
        .UNIT_W      (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input bit p, input logic [3:0] note, input logic [7:0] hold);
        ev_t e;
        e.is_press = p;
        e.note     = note;
        e.hold     = hold;
        q.push_back(e);
    endtask

    function automatic logic [31:0] all_out();
        return {8'd0, u_if.keys_stable, u_if.note_out, u_if.press_pulse,
                u_if.release_pulse, u_if.hold_ticks, u_if.multi_press};
    endfunction

    // Event monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (u_if.press_pulse && u_if.release_pulse) begin
                chk("press_and_release_overlap", 32'd1, 32'd0);
            end
            if (u_if.press_pulse || u_if.release_pulse) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {31'd0, u_if.press_pulse}, 32'hDEAD);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("event_kind", {31'd0, u_if.press_pulse}, {31'd0, e.is_press});
                    if (e.is_press) begin
                        chk("press_note", {28'd0, u_if.note_out}, {28'd0, e.note});
                    end else begin
                        chk("release_note_rest", {28'd0, u_if.note_out}, 32'd0);
                        chk("release_hold_ticks", {24'd0, u_if.hold_ticks}, {24'd0, e.hold});
                    end
                end
            end
        end
    end

    initial begin
        u_if.keys = 7'h00;

        // 1: all keys held through reset
        u_if.keys = 7'h7F;
        reset = 1'b0;
        tick(3);
        chk("reset_outputs_zero", all_out(), 32'd0);
        push_ev(1'b1, 4'd1, 8'd0);
        reset = 1'b1;
        tick(5);
        chk("t1_stable_pre", {25'd0, u_if.keys_stable}, 32'd0);
        tick(1);
        chk("t1_stable_c6", {25'd0, u_if.keys_stable}, 32'h7F);
        chk("t1_note_c6", {28'd0, u_if.note_out}, 32'd0);
        tick(1);
        chk("t1_note_c7", {28'd0, u_if.note_out}, 32'd1);
        chk("t1_press_c7", {31'd0, u_if.press_pulse}, 32'd1);
        u_if.keys = 7'h00;
        push_ev(1'b0, 4'd0, 8'd0);
        tick(1);
        chk("t1_multi", {31'd0, u_if.multi_press}, 32'd1);
        tick(10);
        chk("t1_note_rest", {28'd0, u_if.note_out}, 32'd0);
        chk("t1_multi_clear", {31'd0, u_if.multi_press}, 32'd0);

        // 2: bouncing keys[2]
        push_ev(1'b1, 4'd3, 8'd0);
        u_if.keys = 7'h04; tick(1);
        chk("t2_bounce0", {25'd0, u_if.keys_stable}, 32'd0);
        u_if.keys = 7'h00; tick(1);
        chk("t2_bounce1", {25'd0, u_if.keys_stable}, 32'd0);
        u_if.keys = 7'h04; tick(1);
        chk("t2_bounce2", {25'd0, u_if.keys_stable}, 32'd0);
        u_if.keys = 7'h00; tick(1);
        chk("t2_bounce3", {25'd0, u_if.keys_stable}, 32'd0);
        u_if.keys = 7'h04;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk("t2_settle", {25'd0, u_if.keys_stable}, 32'd0);
        end
        tick(1);
        chk("t2_stable_rise", {25'd0, u_if.keys_stable}, 32'h04);
        tick(1);
        chk("t2_note3", {28'd0, u_if.note_out}, 32'd3);

        // 4: add keys[0] while keys[2] held, then hand over
        tick(13);
        u_if.keys = 7'h05;
        tick(20);
        chk("t4_note_stays3", {28'd0, u_if.note_out}, 32'd3);
        chk("t4_multi", {31'd0, u_if.multi_press}, 32'd1);
        u_if.keys = 7'h01;
        push_ev(1'b0, 4'd0, 8'd3);
        push_ev(1'b1, 4'd1, 8'd0);
        tick(6);
        chk("t4_still3", {28'd0, u_if.note_out}, 32'd3);
        tick(1);
        chk("t4_release", {31'd0, u_if.release_pulse}, 32'd1);
        chk("t4_rest_cycle", {28'd0, u_if.note_out}, 32'd0);
        tick(1);
        chk("t4_handover_note", {28'd0, u_if.note_out}, 32'd1);
        chk("t4_handover_press", {31'd0, u_if.press_pulse}, 32'd1);
        chk("t4_multi_clear", {31'd0, u_if.multi_press}, 32'd0);
        tick(12);
        u_if.keys = 7'h00;
        push_ev(1'b0, 4'd0, 8'd1);
        tick(15);

        // 3: keys[4] for 55 stable cycles
        push_ev(1'b1, 4'd5, 8'd0);
        push_ev(1'b0, 4'd0, 8'd5);
        u_if.keys = 7'h10;
        tick(55);
        u_if.keys = 7'h00;
        tick(15);
        chk("t3_hold_kept", {24'd0, u_if.hold_ticks}, 32'd5);

        // 5: long hold saturates
        push_ev(1'b1, 4'd2, 8'd0);
        push_ev(1'b0, 4'd0, 8'd255);
        u_if.keys = 7'h02;
        tick(30100);
        chk("t5_note2", {28'd0, u_if.note_out}, 32'd2);
        u_if.keys = 7'h00;
        tick(15);

        // 6: reset mid-HELD
        push_ev(1'b1, 4'd4, 8'd0);
        u_if.keys = 7'h08;
        tick(20);
        chk("t6_note4", {28'd0, u_if.note_out}, 32'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_reset_outputs", all_out(), 32'd0);
        push_ev(1'b1, 4'd4, 8'd0);
        push_ev(1'b0, 4'd0, 8'd2);
        tick(2);
        chk("t6_in_reset", all_out(), 32'd0);
        reset = 1'b1;
        tick(7);
        chk("t6_repress_note", {28'd0, u_if.note_out}, 32'd4);
        chk("t6_repress_pulse", {31'd0, u_if.press_pulse}, 32'd1);
        tick(23);
        u_if.keys = 7'h00;
        tick(15);

        for (int i = 0; i < 100 && q.size() != 0; i++) tick(1);
        chk("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
